sd_spi_master: RTL

- Parametrised SPI master for the SD-card peripheral. Replaces the fixed 8-bit, free-running shifter with a programmable clock divider, a configurable word width and a one-entry transmit holding register, so words can go back-to-back with no gap.
- Provides valid/ready transmit and receive-strobe handshakes to the bus-side register file.
- Supports "dummy" transfers with CS forced high, used for the SD power-up sequence of at least 74 clocks.
- SPI mode 0 only: SPI_CLK idles low, MISO sampled on the rising edge, MOSI changes on the falling edge.

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_spi_clkgen.sv | 46 ++++
 rtl/sd_spi_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master.
// The init divider assumes a 50 MHz MasterCLK.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DIV_W     = 8;
  localparam bit DEF_MSB_FIRST = 1'b1;

  localparam int SYS_CLK_HZ  = 50_000_000;
  localparam int SD_INIT_HZ  = 400_000;
  // Smallest divider whose SPI clock stays at or below SD_INIT_HZ.
  localparam int SD_INIT_DIV = (SYS_CLK_HZ + 2 * SD_INIT_HZ - 1) / (2 * SD_INIT_HZ) - 1;

endpackage

// File: rtl/sd_spi_clkgen.sv
// SPI half-period timer: latches the divider at load and counts divlat+1 cycles
// per half-period, emitting one-cycle rise/fall strobes at the end of LOW/HIGH.
module sd_spi_clkgen
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  input  logic             high,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] divlat_q, divlat_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic             wrap;

  always_comb begin
    divlat_d = divlat_q;
    phase_d  = phase_q;
    wrap     = (phase_q == divlat_q);
    if (load) begin
      divlat_d = div;
      phase_d  = '0;
    end else if (run) begin
      phase_d = wrap ? '0 : phase_q + 1'b1;
    end
    rise_stb = run && !high && wrap;
    fall_stb = run && high && wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divlat_q <= '0;
      phase_q  <= '0;
    end else begin
      divlat_q <= divlat_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// Mode-0 SPI master with programmable divider, configurable word width and a
// one-entry transmit holding register so consecutive words run back-to-back.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIV_W     = DEF_DIV_W,
  parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  input  logic [DIV_W-1:0]  ClkDiv,
  input  logic              CsAssert,
  input  logic              TxValid,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxDummy,
  output logic              TxReady,
  output logic              RxValid,
  output logic [DATA_W-1:0] RxData,
  output logic              Busy,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_CS
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_dat_q, hold_dat_d;
  logic              hold_dum_q, hold_dum_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_q, cs_d;
  logic              rx_vld_q, rx_vld_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
  logic              rise_stb, fall_stb;

  sd_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk      (MasterCLK),
    .rst      (Reset),
    .load     (state_q == ST_LOAD),
    .div      (ClkDiv),
    .run      ((state_q == ST_LOW) || (state_q == ST_HIGH)),
    .high     (state_q == ST_HIGH),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_dat_d  = hold_dat_q;
    hold_dum_d  = hold_dum_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;
    rx_vld_d    = 1'b0;
    rx_dat_d    = rx_dat_q;

    if (TxValid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_dat_d  = TxData;
      hold_dum_d  = TxDummy;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b1;
        cs_d   = !CsAssert;
        if (hold_full_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d     = hold_dat_q;
        hold_full_d = 1'b0;
        cs_d        = hold_dum_q || !CsAssert;
        mosi_d      = MSB_FIRST ? hold_dat_q[DATA_W-1] : hold_dat_q[0];
        bitcnt_d    = '0;
        state_d     = ST_LOW;
      end
      ST_LOW: begin
        if (rise_stb) begin
          sclk_d  = 1'b1;
          // Sample on the rise; the vacated end then holds the next bit to send.
          shift_d = MSB_FIRST ? {shift_q[DATA_W-2:0], SPI_MISO}
                              : {SPI_MISO, shift_q[DATA_W-1:1]};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall_stb) begin
          sclk_d   = 1'b0;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
          end else begin
            mosi_d  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
            state_d = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        rx_vld_d = 1'b1;
        rx_dat_d = shift_q;
        state_d  = hold_full_q ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_dat_q  <= '0;
      hold_dum_q  <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      cs_q        <= 1'b1;
      rx_vld_q    <= 1'b0;
      rx_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_dat_q  <= hold_dat_d;
      hold_dum_q  <= hold_dum_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      rx_vld_q    <= rx_vld_d;
      rx_dat_q    <= rx_dat_d;
    end
  end

  assign TxReady  = !hold_full_q;
  assign Busy     = (state_q != ST_IDLE) || hold_full_q;
  assign RxValid  = rx_vld_q;
  assign RxData   = rx_dat_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = cs_q;

endmodule
